// File: rtl/hazard_pkg.sv
// Shared types and constants for the 3-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALL_W = 2'd1,
    RET_W  = 2'd2,
    INT_W  = 2'd3
  } state_e;

  localparam logic [1:0] RSRC_BRANCH = 2'd0;
  localparam logic [1:0] RSRC_RET    = 2'd1;
  localparam logic [1:0] RSRC_INT    = 2'd2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Status inputs from decode/execute and pipeline control outputs of the hazard controller.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3
);
  logic                  branch_decision;
  logic                  push_pc;
  logic                  pop_pc;
  logic                  exm_imm;
  logic                  interrupt;
  logic                  fetch_hazard_instruction;
  logic                  decode_hazard_instruction;
  logic                  em_mem_read;
  logic [REG_ADDR_W-1:0] em_rd;
  logic [REG_ADDR_W-1:0] d_rs1;
  logic [REG_ADDR_W-1:0] d_rs2;
  logic [1:0]            d_rs_valid;

  logic                  flush_f_d;
  logic                  flush_d_em;
  logic                  stall_f_d;
  logic                  stall_d_em;
  logic                  pc_redirect;
  logic [1:0]            redirect_src;
  logic                  int_ack;
  logic [1:0]            state;

  // Pipeline side: drives status, consumes controls.
  modport master (
    output branch_decision, push_pc, pop_pc, exm_imm, interrupt,
           fetch_hazard_instruction, decode_hazard_instruction,
           em_mem_read, em_rd, d_rs1, d_rs2, d_rs_valid,
    input  flush_f_d, flush_d_em, stall_f_d, stall_d_em,
           pc_redirect, redirect_src, int_ack, state
  );

  // Hazard controller side.
  modport slave (
    input  branch_decision, push_pc, pop_pc, exm_imm, interrupt,
           fetch_hazard_instruction, decode_hazard_instruction,
           em_mem_read, em_rd, d_rs1, d_rs2, d_rs_valid,
    output flush_f_d, flush_d_em, stall_f_d, stall_d_em,
           pc_redirect, redirect_src, int_ack, state
  );
endinterface

// File: rtl/hazard_stall_counter.sv
// Loadable down-counter timing the CALL/RET/interrupt stall windows; saturates at zero.
module hazard_stall_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Flush/stall/redirect controller for the F/D/EM pipeline (branch, CALL, RET, interrupt entry).
// Define HAZARD_LOAD_USE_EN to enable load-use bubble insertion.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CALL_STALL_CYCLES = 1,
  parameter int RET_STALL_CYCLES  = 1,
  parameter int INT_STALL_CYCLES  = 2,
  parameter int REG_ADDR_W        = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  hazard_ctrl_if.slave hz
);

  localparam int CNT_W = $clog2(max3(CALL_STALL_CYCLES, RET_STALL_CYCLES, INT_STALL_CYCLES) + 1);

  state_e           state_q, state_d;
  logic             int_pending_q, int_pending_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_val;
  logic             accept;
  logic             flush_f_d, flush_d_em, stall_f_d, stall_d_em, redirect;
  logic [1:0]       src;
  logic             load_use;

  logic [REG_ADDR_W-1:0] em_rd, d_rs1, d_rs2;
  assign em_rd = hz.em_rd;
  assign d_rs1 = hz.d_rs1;
  assign d_rs2 = hz.d_rs2;

`ifdef HAZARD_LOAD_USE_EN
  assign load_use = hz.em_mem_read &&
                    ((hz.d_rs_valid[0] && (d_rs1 == em_rd)) ||
                     (hz.d_rs_valid[1] && (d_rs2 == em_rd)));
`else
  // Software schedules around load-use; these inputs are intentionally ignored.
  logic unused_load_use;
  assign unused_load_use = ^{hz.em_mem_read, em_rd, d_rs1, d_rs2, hz.d_rs_valid};
  assign load_use = 1'b0;
`endif

  hazard_stall_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (cnt_load_val),
    .i_dec      (cnt_dec),
    .o_cnt      (cnt_val),
    .o_zero     (cnt_zero)
  );

  logic unused_cnt_val;
  assign unused_cnt_val = ^cnt_val;

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    accept       = 1'b0;
    flush_f_d    = 1'b0;
    flush_d_em   = 1'b0;
    stall_f_d    = 1'b0;
    stall_d_em   = 1'b0;
    redirect     = 1'b0;
    src          = RSRC_BRANCH;
    case (state_q)
      IDLE: begin
        if (hz.branch_decision) begin
          flush_f_d  = 1'b1;
          flush_d_em = 1'b1;
          redirect   = 1'b1;
        end else if (hz.push_pc || hz.pop_pc) begin
          stall_f_d  = 1'b1;
          stall_d_em = 1'b1;
          cnt_load   = 1'b1;
          if (hz.pop_pc) begin
            state_d      = RET_W;
            cnt_load_val = CNT_W'(RET_STALL_CYCLES - 1);
          end else begin
            state_d      = CALL_W;
            cnt_load_val = CNT_W'(CALL_STALL_CYCLES - 1);
          end
        end else if (int_pending_q && !hz.fetch_hazard_instruction &&
                     !hz.decode_hazard_instruction) begin
          accept       = 1'b1;
          flush_f_d    = 1'b1;
          stall_d_em   = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(INT_STALL_CYCLES - 1);
          state_d      = INT_W;
        end else if (load_use) begin
          stall_f_d  = 1'b1;
          flush_d_em = 1'b1;
        end
      end
      CALL_W, RET_W, INT_W: begin
        // EM is frozen here, so branch/call/ret inputs are stale and ignored.
        if (!cnt_zero) begin
          stall_f_d  = 1'b1;
          stall_d_em = 1'b1;
          cnt_dec    = 1'b1;
        end else begin
          state_d = IDLE;
          if (state_q != CALL_W) begin
            flush_f_d  = 1'b1;
            flush_d_em = 1'b1;
            redirect   = 1'b1;
            src        = (state_q == RET_W) ? RSRC_RET : RSRC_INT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign int_pending_d = (int_pending_q && !accept) || hz.interrupt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= IDLE;
      int_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      int_pending_q <= int_pending_d;
    end
  end

  // Outputs forced low during reset; flush_f_d wins over stall_f_d.
  assign hz.flush_f_d    = !i_rst && flush_f_d;
  assign hz.flush_d_em   = !i_rst && (flush_d_em || hz.exm_imm);
  assign hz.stall_f_d    = !i_rst && stall_f_d && !flush_f_d;
  assign hz.stall_d_em   = !i_rst && stall_d_em;
  assign hz.pc_redirect  = !i_rst && redirect;
  assign hz.redirect_src = i_rst ? 2'd0 : src;
  assign hz.int_ack      = !i_rst && accept;
  assign hz.state        = i_rst ? 2'd0 : state_q;

endmodule
